// File: rtl/vga_timing_rx.sv
// vga_timing_rx: recovers column/row/active timing from a VGA sync pair
// sampled on PClk ticks of Clk50, with a SEARCH/HLOCK/LOCKED lock tracker.
module vga_timing_rx #(
    parameter int H_TOTAL     = 800,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_LEN   = 640,
    parameter int V_TOTAL     = 525,
    parameter int V_ACT_START = 34,
    parameter int V_ACT_LEN   = 480
) (
    input  logic       Clk50,
    input  logic       Reset,
    input  logic       PClk,
    input  logic       HSync,
    input  logic       VSync,
    output logic [9:0] Col,
    output logic [8:0] Row,
    output logic       Active,
    output logic       Col0,
    output logic       Row0,
    output logic       Locked,
    output logic       SyncErr
);

    typedef enum logic [1:0] {SEARCH, HLOCK, LOCKED} state_e;

    localparam logic [10:0] HTOT = 11'(H_TOTAL);
    localparam logic [10:0] VTOT = 11'(V_TOTAL);
    localparam logic [9:0]  HA0  = 10'(H_ACT_START);
    localparam logic [9:0]  HA1  = 10'(H_ACT_START + H_ACT_LEN);
    localparam logic [9:0]  VA0  = 10'(V_ACT_START);
    localparam logic [9:0]  VA1  = 10'(V_ACT_START + V_ACT_LEN);
    localparam logic [9:0]  CMAX = 10'h3ff;

    state_e      state_q, state_d;
    logic        hs_meta_q, hs_meta_d, hs_sync_q, hs_sync_d;
    logic        vs_meta_q, vs_meta_d, vs_sync_q, vs_sync_d;
    logic        hs_hist_q, hs_hist_d, vs_hist_q, vs_hist_d;
    logic [9:0]  hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic        pend_q, pend_d, armed_q, armed_d;
    logic [1:0]  lcnt_q, lcnt_d, fcnt_q, fcnt_d;
    logic [9:0]  col_q, col_d;
    logic [8:0]  row_q, row_d;
    logic        active_q, active_d, col0_q, col0_d, row0_q, row0_d;
    logic        locked_q, locked_d, err_q, err_d;

    logic        h_edge, v_edge, v_reset, h_err, v_err, sync_err;
    logic [10:0] h_len, v_len;
    logic        hact, vact;

    always_comb begin
        h_edge   = PClk & hs_hist_q & ~hs_sync_q;
        v_edge   = PClk & vs_hist_q & ~vs_sync_q;
        v_reset  = h_edge & pend_q;
        h_len    = {1'b0, hcnt_q} + 11'd1;
        v_len    = {1'b0, vcnt_q} + 11'd1;
        h_err    = h_edge & (h_len != HTOT);
        v_err    = v_reset & armed_q & (v_len != VTOT);
        sync_err = h_err | v_err;
    end

    always_comb begin
        hs_meta_d = HSync;
        hs_sync_d = hs_meta_q;
        vs_meta_d = VSync;
        vs_sync_d = vs_meta_q;
        hs_hist_d = hs_hist_q;
        vs_hist_d = vs_hist_q;
        hcnt_d    = hcnt_q;
        vcnt_d    = vcnt_q;
        pend_d    = pend_q;
        if (PClk) begin
            hs_hist_d = hs_sync_q;
            vs_hist_d = vs_sync_q;
            if (h_edge)
                hcnt_d = '0;
            else if (hcnt_q != CMAX)
                hcnt_d = hcnt_q + 10'd1;
        end
        // A V edge only arms the row reset; the next H edge applies it
        if (h_edge) begin
            if (pend_q)
                vcnt_d = '0;
            else if (vcnt_q != CMAX)
                vcnt_d = vcnt_q + 10'd1;
        end
        if (v_edge)
            pend_d = 1'b1;
        else if (v_reset)
            pend_d = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SEARCH:
                if (h_edge && !h_err && lcnt_q == 2'd1)
                    state_d = HLOCK;
            HLOCK:
                if (sync_err)
                    state_d = SEARCH;
                else if (v_reset && armed_q && fcnt_q == 2'd1)
                    state_d = LOCKED;
            LOCKED:
                if (sync_err)
                    state_d = SEARCH;
            default:
                state_d = SEARCH;
        endcase
    end

    always_comb begin
        lcnt_d  = lcnt_q;
        fcnt_d  = fcnt_q;
        armed_d = armed_q;
        if (state_q == SEARCH && h_edge)
            lcnt_d = h_err ? 2'd0 : lcnt_q + 2'd1;
        if (state_q == HLOCK && v_reset && armed_q && !sync_err)
            fcnt_d = fcnt_q + 2'd1;
        if (state_d != state_q) begin
            lcnt_d = '0;
            fcnt_d = '0;
        end
        // The frame closed by the first row reset after losing lock is partial
        if (state_q != SEARCH && state_d == SEARCH)
            armed_d = 1'b0;
        else if (v_reset)
            armed_d = 1'b1;
    end

    always_comb begin
        locked_d = (state_d == LOCKED);
        hact     = (hcnt_d >= HA0) && (hcnt_d < HA1);
        vact     = (vcnt_d >= VA0) && (vcnt_d < VA1);
        active_d = hact & vact & locked_d;
        col_d    = active_d ? hcnt_d - HA0 : '0;
        row_d    = active_d ? vcnt_d[8:0] - VA0[8:0] : '0;
        col0_d   = active_d & (hcnt_d == HA0);
        row0_d   = col0_d & (vcnt_d == VA0);
        err_d    = sync_err;
    end

    always_ff @(posedge Clk50) begin
        if (Reset) begin
            state_q   <= SEARCH;
            hs_meta_q <= 1'b1;
            hs_sync_q <= 1'b1;
            vs_meta_q <= 1'b1;
            vs_sync_q <= 1'b1;
            hs_hist_q <= 1'b0;
            vs_hist_q <= 1'b0;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            pend_q    <= 1'b0;
            armed_q   <= 1'b0;
            lcnt_q    <= '0;
            fcnt_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            active_q  <= 1'b0;
            col0_q    <= 1'b0;
            row0_q    <= 1'b0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hs_meta_q <= hs_meta_d;
            hs_sync_q <= hs_sync_d;
            vs_meta_q <= vs_meta_d;
            vs_sync_q <= vs_sync_d;
            hs_hist_q <= hs_hist_d;
            vs_hist_q <= vs_hist_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            pend_q    <= pend_d;
            armed_q   <= armed_d;
            lcnt_q    <= lcnt_d;
            fcnt_q    <= fcnt_d;
            if (PClk) begin
                col_q    <= col_d;
                row_q    <= row_d;
                active_q <= active_d;
                col0_q   <= col0_d;
                row0_q   <= row0_d;
                locked_q <= locked_d;
                err_q    <= err_d;
            end
        end
    end

    assign Col     = col_q;
    assign Row     = row_q;
    assign Active  = active_q;
    assign Col0    = col0_q;
    assign Row0    = row0_q;
    assign Locked  = locked_q;
    assign SyncErr = err_q;

endmodule
